bin2bcd_seq16: RTL and testbench

- Sequential binary-to-BCD converter that sits directly downstream of the 16-bit result/operand register in the simple calculator.
- Takes the 16-bit registered value and converts it to five packed BCD digits for the 7-segment display driver.
- Uses iterative shift-add-3 (double dabble), one bit per clock, with a start/busy/done handshake so the display path only updates on completed conversions.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 25 ++
 rtl/bin2bcd_seq16.sv | 148 ++++++++++++++
 tb/tb_bin2bcd_seq16.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator display path: datapath sizes, the
// binary-to-BCD converter state encoding and the packed BCD result type.
// No ports (package).
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_WIDTH  = 16;  // width of the result/operand register
  localparam int CALC_DIGITS = 5;   // decimal digits needed for 16 bits
  localparam int CALC_CNT_W  = 5;   // bit counter width, must hold CALC_WIDTH

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // Packed BCD: [3:0] units ... [19:16] ten-thousands.
  typedef logic [4*CALC_DIGITS-1:0] bcd_t;

endpackage : calc_pkg

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for one BCD nibble: adds 3 when the nibble is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit. Purely combinational.
//
// Ports:
//   digit_i  in  4  BCD nibble before correction
//   digit_o  out 4  corrected nibble (4-bit result, no carry out)
// -----------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // NOTE: always_comb assigns digit_o on every path, so no latch is inferred.
  always_comb begin
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq16.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq16
// Sequential binary-to-BCD converter (double dabble, one bit per clock) that
// sits between the calculator result register and the 7-segment driver.
// A conversion is accepted from IDLE on start, runs WIDTH SHIFT cycles and
// then spends one DONE cycle pulsing done while bcd_out presents the result.
//
// Build option: BIN2BCD_SIGNED_EN
//   defined   -> bin_in is two's complement; |bin_in| is converted and neg_out
//                reports the sign, updated together with bcd_out.
//   undefined -> bin_in is unsigned and neg_out is tied to 0.
//
// Ports:
//   clock    in  1         system clock, rising edge
//   reset    in  1         synchronous, active-high reset
//   start    in  1         conversion request, sampled only in IDLE
//   bin_in   in  WIDTH     binary value, captured on the accepted start edge
//   busy     out 1         high whenever not IDLE
//   done     out 1         one-cycle pulse, bcd_out newly valid
//   bcd_out  out 4*DIGITS  last completed result, packed BCD
//   neg_out  out 1         sign of the last completed result
// -----------------------------------------------------------------------------
module bin2bcd_seq16
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS,
  parameter int CNT_W  = CALC_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out
);

  bcd_state_e            state_q;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d, scratch_adj;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [WIDTH-1:0]      load_val;

  // Correct every nibble in parallel before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

  always_comb begin
    {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
  end

`ifdef BIN2BCD_SIGNED_EN
  logic neg_pend_q;   // sign captured at start, published at DONE
  logic neg_q;

  // Magnitude of a two's-complement value; the most negative input maps to
  // 2**(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  always_comb begin
    if (bin_in[WIDTH-1]) begin
      load_val = WIDTH'(~bin_in + 1'b1);
    end else begin
      load_val = bin_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else if (state_q == IDLE && start) begin
      neg_pend_q <= bin_in[WIDTH-1];
    end else if (state_q == SHIFT && cnt_q == CNT_W'(1)) begin
      neg_q      <= neg_pend_q;
    end
  end

  assign neg_out = neg_q;
`else
  assign load_val = bin_in;
  assign neg_out  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: scratch/shift/counter are reset as well so an aborted
      // conversion leaves no stale partial result behind.
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_q   <= load_val;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - 1'b1;
          // Last bit is shifted in on this edge: publish the post-shift value.
          if (cnt_q == CNT_W'(1)) begin
            bcd_q   <= scratch_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule : bin2bcd_seq16

// File: tb/tb_bin2bcd_seq16.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq16
// Self-checking bench for bin2bcd_seq16: boundary vector table, randomized
// values against a decimal reference model, and hand-written sequences for
// handshake corner cases (ignored start, reset abort, back-to-back).
// Honours BIN2BCD_SIGNED_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq16;

  localparam int W     = 16;
  localparam int LAT   = W + 1;   // edge at which done is sampled high
  localparam int PERIOD = W + 2;  // back-to-back throughput

  logic        clock, reset, start;
  logic [15:0] bin_in;
  logic        busy, done, neg_out;
  logic [19:0] bcd_out;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq16 dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .neg_out (neg_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        neg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits of the (magnitude of the) value.
  function automatic void model(input logic [15:0] v, output logic [19:0] bcd,
                                output logic neg);
    int m;
    m   = int'(v);
    neg = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (v[15]) begin
      m   = 65536 - int'(v);
      neg = 1'b1;
    end
`endif
    bcd = '0;
    for (int d = 0; d < 5; d++) begin
      bcd[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  // Start a conversion and wait (bounded) for done. lat counts clock edges
  // from the start edge to the edge at which done is sampled high.
  task automatic run_conv(input logic [15:0] v, output logic [19:0] bcd,
                          output logic neg, output int lat, output logic busy_all);
    int n;
    @(negedge clock);
    bin_in = v;
    start  = 1'b1;
    @(posedge clock);              // start edge E
    @(negedge clock);
    start  = 1'b0;
    bin_in = 16'($urandom);        // must not disturb the capture
    n = 0;
    busy_all = 1'b1;
    while (!done && n < 40) begin
      busy_all &= busy;
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    busy_all &= busy;
    check("done_seen", 32'(done), 32'd1);
    lat = n + 1;
    bcd = bcd_out;
    neg = neg_out;
  endtask

  logic [19:0] got_bcd, exp_bcd;
  logic        got_neg, exp_neg, busy_all;
  int          lat, first, second, ndone;
  logic [15:0] rv;

  initial begin
    // Boundary table.
    vecs.push_back('{16'd0,     20'h00000, 1'b0});
    vecs.push_back('{16'd9,     20'h00009, 1'b0});
    vecs.push_back('{16'd10,    20'h00010, 1'b0});
    vecs.push_back('{16'd1234,  20'h01234, 1'b0});
`ifdef BIN2BCD_SIGNED_EN
    vecs.push_back('{16'hFFFF,  20'h00001, 1'b1});
    vecs.push_back('{16'h8000,  20'h32768, 1'b1});
    vecs.push_back('{16'h7FFF,  20'h32767, 1'b0});
`else
    vecs.push_back('{16'd65535, 20'h65535, 1'b0});
    vecs.push_back('{16'h8000,  20'h32768, 1'b0});
`endif

    // Reset held 2 cycles with start asserted: reset must win.
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 16'd1234;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_done", 32'(done),    32'd0);
    check("rst_bcd",  32'(bcd_out), 32'd0);
    check("rst_neg",  32'(neg_out), 32'd0);

    // Basic conversion with latency and busy profile.
    run_conv(16'd1234, got_bcd, got_neg, lat, busy_all);
    check("basic_bcd", 32'(got_bcd), 32'h01234);
    check("basic_lat", 32'(lat), 32'(LAT));
    check("basic_busy_high", 32'(busy_all), 32'd1);
    @(posedge clock);
    @(negedge clock);
    check("basic_busy_low", 32'(busy), 32'd0);
    check("basic_done_low", 32'(done), 32'd0);
    check("basic_bcd_hold", 32'(bcd_out), 32'h01234);

    // Table-driven boundary vectors.
    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, got_bcd, got_neg, lat, busy_all);
      check($sformatf("vec%0d_bcd", i), 32'(got_bcd), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_neg", i), 32'(got_neg), 32'(vecs[i].neg));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // Randomized values against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv = 16'($urandom);
      model(rv, exp_bcd, exp_neg);
      run_conv(rv, got_bcd, got_neg, lat, busy_all);
      check($sformatf("rand_bcd_%0h", rv), 32'(got_bcd), 32'(exp_bcd));
      check($sformatf("rand_neg_%0h", rv), 32'(got_neg), 32'(exp_neg));
    end

    // Start while busy is ignored and not queued.
    @(negedge clock);
    bin_in = 16'd100;
    start  = 1'b1;
    @(posedge clock);              // E
    @(negedge clock);
    start = 1'b0;
    repeat (4) begin
      @(posedge clock);
      @(negedge clock);
    end
    bin_in = 16'd999;
    start  = 1'b1;                 // sampled at E+5
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    got_bcd = '0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ndone++;
        got_bcd = bcd_out;
      end
      @(posedge clock);
      @(negedge clock);
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_bcd", 32'(got_bcd), 32'h00100);

    // Reset mid-conversion aborts and clears the result.
    @(negedge clock);
    bin_in = 16'd7777;
    start  = 1'b1;
    @(posedge clock);              // E
    @(negedge clock);
    start = 1'b0;
    repeat (7) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;                  // sampled at E+8
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 32'(busy),    32'd0);
    check("abort_bcd",  32'(bcd_out), 32'd0);
    check("abort_done", 32'(done),    32'd0);
    ndone = 0;
    repeat (20) begin
      @(posedge clock);
      @(negedge clock);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_conv(16'd42, got_bcd, got_neg, lat, busy_all);
    check("abort_next_bcd", 32'(got_bcd), 32'h00042);
    check("abort_next_lat", 32'(lat), 32'(LAT));

    // Back-to-back: start held high.
    @(negedge clock);
    bin_in = 16'd321;
    start  = 1'b1;
    first  = -1;
    second = -1;
    for (int i = 0; i < 60 && second < 0; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        if (first < 0) first = i;
        else second = i;
      end
    end
    start = 1'b0;
    check("b2b_period", 32'(second - first), 32'(PERIOD));
    check("b2b_bcd", 32'(bcd_out), 32'h00321);
    repeat (25) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bin2bcd_seq16
